// File: rtl/mskaes_kat_sequencer.sv
// Known-answer-test sequencer for the masked AES-128 core: shares each vector, runs it, unmasks and checks.
// Optional KAT_STOP_ON_FAIL_EN ends the run at the first mismatching or timed-out vector.
module mskaes_kat_sequencer #(
   parameter int d           = 2,
   parameter int NVEC        = 4,
   parameter int RESEED_WAIT = 30,
   parameter int TIMEOUT     = 255,
   parameter int CW          = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [128*NVEC-1:0]    vec_pt,
   input  logic [128*NVEC-1:0]    vec_key,
   input  logic [128*NVEC-1:0]    vec_ct,
   input  logic [256*(d-1)-1:0]   rnd,
   input  logic                   dut_ready,
   input  logic                   dut_cipher_valid,
   input  logic [128*d-1:0]       dut_sh_ciphertext,
   input  logic                   prng_out_valid,
   output logic                   dut_valid_in,
   output logic [128*d-1:0]       dut_sh_plaintext,
   output logic [128*d-1:0]       dut_sh_key,
   output logic                   prng_start_reseed,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [8:0]             fail_cnt,
   output logic [7:0]             first_fail,
   output logic [CW-1:0]          last_lat,
   output logic                   timeout_err
);

`ifdef KAT_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   localparam int              WW        = $clog2(RESEED_WAIT + 1) + 1;
   localparam logic [WW-1:0]   WAIT_LAST = WW'(RESEED_WAIT - 1);
   localparam logic [CW-1:0]   LAT_TO    = CW'(TIMEOUT);
   localparam logic [7:0]      IDX_LAST  = 8'(NVEC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RESEED, S_WAIT_PRNG, S_ISSUE, S_RUN, S_CHECK, S_NEXT, S_DONE
   } state_t;

   state_t              state, nxt;
   logic [7:0]          idx, sel_idx;
   logic [WW-1:0]       wcnt;
   logic [CW-1:0]       lat;
   logic [127:0]        ct_q, ct_plain, sel_pt, sel_key;
   logic [128*d-1:0]    sh_pt_n, sh_key_n;
   logic                load_sh, mismatch, acc_p, acc_k, rp, rk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt               = state;
      dut_valid_in      = 1'b0;
      prng_start_reseed = 1'b0;
      busy              = (state != S_IDLE);
      case (state)
         S_IDLE:      if (start) nxt = S_RESEED;
         S_RESEED: begin
            prng_start_reseed = 1'b1;
            nxt               = S_WAIT_PRNG;
         end
         S_WAIT_PRNG: if (prng_out_valid || wcnt >= WAIT_LAST) nxt = S_ISSUE;
         S_ISSUE: if (dut_ready) begin
            dut_valid_in = 1'b1;
            nxt          = S_RUN;
         end
         S_RUN: begin
            if (dut_cipher_valid)   nxt = S_CHECK;
            else if (lat == LAT_TO) nxt = STOP_ON_FAIL ? S_DONE : S_NEXT;
         end
         S_CHECK:     nxt = (mismatch && STOP_ON_FAIL) ? S_DONE : S_NEXT;
         S_NEXT:      nxt = (idx == IDX_LAST) ? S_DONE : S_ISSUE;
         S_DONE:      nxt = S_IDLE;
         default:     nxt = S_IDLE;
      endcase
      // Shares are loaded on entry to ISSUE so they are already valid on the valid_in cycle.
      load_sh = (nxt == S_ISSUE) && (state != S_ISSUE);
   end

   always_comb begin
      sel_idx  = (state == S_NEXT) ? idx + 8'd1 : idx;
      sel_pt   = vec_pt[int'(sel_idx)*128 +: 128];
      sel_key  = vec_key[int'(sel_idx)*128 +: 128];
      mismatch = (ct_q != vec_ct[int'(idx)*128 +: 128]);
      sh_pt_n  = '0;
      sh_key_n = '0;
      ct_plain = '0;
      acc_p    = 1'b0;
      acc_k    = 1'b0;
      rp       = 1'b0;
      rk       = 1'b0;
      for (int unsigned i = 0; i < 128; i++) begin
         ct_plain[i] = ^dut_sh_ciphertext[d*i +: d];
         acc_p = sel_pt[i];
         acc_k = sel_key[i];
         for (int unsigned j = 1; j < d; j++) begin
            rp = rnd[(d-1)*i + j - 1];
            rk = rnd[128*(d-1) + (d-1)*i + j - 1];
            sh_pt_n[d*i + j]  = rp;
            sh_key_n[d*i + j] = rk;
            acc_p = acc_p ^ rp;
            acc_k = acc_k ^ rk;
         end
         sh_pt_n[d*i]  = acc_p;
         sh_key_n[d*i] = acc_k;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx              <= '0;
         wcnt             <= '0;
         lat              <= '0;
         ct_q             <= '0;
         dut_sh_plaintext <= '0;
         dut_sh_key       <= '0;
         done             <= 1'b0;
         pass             <= 1'b0;
         fail_cnt         <= '0;
         first_fail       <= 8'hFF;
         last_lat         <= '0;
         timeout_err      <= 1'b0;
      end else begin
         if (load_sh) begin
            dut_sh_plaintext <= sh_pt_n;
            dut_sh_key       <= sh_key_n;
         end
         case (state)
            S_IDLE: if (start) begin
               fail_cnt    <= '0;
               timeout_err <= 1'b0;
               done        <= 1'b0;
               pass        <= 1'b0;
               first_fail  <= 8'hFF;
               idx         <= '0;
            end
            S_RESEED:    wcnt <= WW'(1);
            S_WAIT_PRNG: wcnt <= wcnt + 1'b1;
            // Counter starts at 1 so a reply on the cycle after the pulse reports latency 1.
            S_ISSUE:     if (dut_ready) lat <= CW'(1);
            S_RUN: begin
               lat <= (lat == '1) ? lat : lat + 1'b1;
               if (dut_cipher_valid) begin
                  ct_q     <= ct_plain;
                  last_lat <= lat;
               end else if (lat == LAT_TO) begin
                  timeout_err <= 1'b1;
                  fail_cnt    <= fail_cnt + 9'd1;
                  if (first_fail == 8'hFF) first_fail <= idx;
               end
            end
            S_CHECK: if (mismatch) begin
               fail_cnt <= fail_cnt + 9'd1;
               if (first_fail == 8'hFF) first_fail <= idx;
            end
            S_NEXT: if (idx != IDX_LAST) idx <= idx + 8'd1;
            S_DONE: begin
               done <= 1'b1;
               pass <= (fail_cnt == '0) && !timeout_err;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mskaes_kat_sequencer.md
Name: mskaes_kat_sequencer

Overview:
Synthesizable known-answer-test sequencer for the masked AES-128 wrapper. It drives NVEC plaintext/key/ciphertext vectors through the core and handles PRNG reseed and the core's handshake. It reconstructs each bit-interleaved shared ciphertext, compares it against the expected value, and reports pass/fail, failure count and measured latency. It replaces hand-written single-vector benches and runs on-chip or in simulation.

Parameters:
d, 2, number of shares for the plaintext and key sharing; output width 128*d
NVEC, 4, number of test vectors, 1..256
RESEED_WAIT, 30, cycles to wait after the reseed pulse when prng_out_valid does not rise
TIMEOUT, 255, maximum cycles from the valid_in pulse to cipher_valid before an error
CW, 16, width of the latency counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse that starts a run; ignored while busy
vec_pt  in  128*NVEC  plaintexts; vector k in [128k +: 128]
vec_key  in  128*NVEC  keys, same layout
vec_ct  in  128*NVEC  expected ciphertexts, same layout
rnd  in  256*(d-1)  fresh mask bits; low half for plaintext, high half for key
dut_ready  in  1  core ready
dut_cipher_valid  in  1  core output valid
dut_sh_ciphertext  in  128*d  shared ciphertext; bit i shares in [d*i +: d]
prng_out_valid  in  1  PRNG seeded indication
dut_valid_in  out  1  one-cycle start pulse to the core
dut_sh_plaintext  out  128*d  shared plaintext, bit-interleaved
dut_sh_key  out  128*d  shared key, bit-interleaved
prng_start_reseed  out  1  one-cycle reseed pulse
busy  out  1  run in progress
done  out  1  high from end of run until the next start
pass  out  1  valid while done; 1 means all vectors matched and no timeout
fail_cnt  out  9  number of mismatching vectors
first_fail  out  8  index of the first failing vector; 8'hFF if none
last_lat  out  CW  cycles from dut_valid_in to dut_cipher_valid for the last vector
timeout_err  out  1  sticky flag; set if any vector timed out

Behaviour:
- Reset values: all outputs 0 except first_fail=8'hFF. State goes to IDLE. An asserted reset aborts any run immediately; there is no partial reporting.
- Sharing, latched in ISSUE:
  - For each bit i, shares 1..d-1 come from rnd and share 0 = bit XOR (XOR of shares 1..d-1).
  - Shares are registered. They are held stable from the valid_in pulse until CHECK.
  - d=1 is not supported.
- States:
  - IDLE: on start, clear fail_cnt, timeout_err, done and pass; set first_fail=FF and idx=0; go to RESEED.
  - RESEED: prng_start_reseed=1 for exactly one cycle; go to WAIT_PRNG.
  - WAIT_PRNG: go to ISSUE when prng_out_valid=1 or the wait counter reaches RESEED_WAIT, whichever comes first.
  - ISSUE: latch shares of vector idx. When dut_ready=1, assert dut_valid_in for one cycle, clear the latency counter and go to RUN.
  - RUN:
    - The latency counter increments each cycle and saturates at all-ones.
    - On dut_cipher_valid=1, capture the unmasked ciphertext (XOR over the d shares per bit) and the counter into last_lat; go to CHECK.
    - If the counter equals TIMEOUT with no cipher_valid: set timeout_err, count the vector as failed, go to NEXT.
    - Latency convention: if cipher_valid arrives on the cycle after the pulse, last_lat=1.
  - CHECK: on mismatch with vec_ct[idx], increment fail_cnt and, if first_fail==FF, set first_fail=idx.
  - NEXT: if idx==NVEC-1, go to DONE; otherwise increment idx and go to ISSUE. No reseed between vectors.
  - DONE: done=1, pass=(fail_cnt==0 && !timeout_err), busy=0; go to IDLE. The flags hold until the next start.
- busy=1 in every state except IDLE.
- A start pulse during busy is ignored.
- A cipher_valid outside RUN is ignored.
- cipher_valid on the same cycle the counter reaches TIMEOUT counts as a valid completion, not a timeout.

Optional Feature:
KAT_STOP_ON_FAIL_EN:
- When defined, the first mismatch or timeout goes directly to DONE. idx is preserved, fail_cnt=1, and first_fail=idx of that vector.
- When undefined, all NVEC vectors always run.

Test Plan:
- NVEC=1, d=2; pt=340737e0a29831318d305a88a8f64332, key=3c4fcf098815f7aba6d2ae2816157e2b, ct=320b6a19978511dcfb09dc021d842539; core model with 10-cycle latency -> pass=1, fail_cnt=0, first_fail=FF, last_lat=10, exactly one prng_start_reseed and one dut_valid_in pulse.
- NVEC=4, vector 2 expected ct bit 0 flipped -> pass=0, fail_cnt=1, first_fail=2. With KAT_STOP_ON_FAIL_EN: done after vector 2, and only 3 valid_in pulses in total.
- Core never raises cipher_valid, TIMEOUT=20 -> timeout_err=1 after 20 cycles in RUN, pass=0, fail_cnt=NVEC.
- prng_out_valid stuck 0 -> ISSUE entered exactly RESEED_WAIT cycles after the reseed pulse. prng_out_valid rising 5 cycles after the pulse -> ISSUE entered on the next cycle.
- dut_ready held 0 for 7 cycles in ISSUE -> no valid_in until ready is high. Sharing check over random rnd -> XOR of the shares of each bit equals pt/key, and shares stay stable until CHECK.
- rst asserted mid-RUN -> all outputs at reset values within the same cycle. A start pulse during busy -> no effect on idx or counters.
